// File: rtl/vend_dispense_arbiter_if.sv
// Dispenser handshake bundle between the vending controller and the shared dispenser.
// disp_req/disp_sel come from the controller; disp_ready/disp_done come back from the dispenser.
interface vend_dispense_arbiter_if;
    logic disp_req;
    logic disp_sel;
    logic disp_ready;
    logic disp_done;

    modport master (
        output disp_req,
        output disp_sel,
        input  disp_ready,
        input  disp_done
    );

    modport slave (
        input  disp_req,
        input  disp_sel,
        output disp_ready,
        output disp_done
    );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Vending machine controller: coin credit, coffee/sprite arbitration, dispenser
// sequencing and timed auto-refund of idle credit.
module vend_dispense_arbiter #(
    parameter int PRICE_COFFEE = 1,
    parameter int PRICE_SPRITE = 3,
    parameter int MAX_CREDIT   = 3,
    parameter int CREDIT_W     = 2,
    parameter int IDLE_TIMEOUT = 5000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        coin,
    input  logic                        req_coffee,
    input  logic                        req_sprite,
    vend_dispense_arbiter_if.master     disp,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        refund_pulse,
    output logic                        coin_return,
    output logic                        deny,
    output logic                        led_coffee,
    output logic                        led_sprite,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    // Dispenser handshake: disp_req is a valid that stays high with disp_sel
    // stable until a cycle where disp_ready=1; that cycle is the transfer and
    // disp_req drops on the next edge. disp_done is a one-cycle completion
    // strobe and is only honoured in WAIT_DONE.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DONE = 2'd2,
        REFUND    = 2'd3
    } state_t;

    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_COFFEE);
    localparam logic [CREDIT_W-1:0] PRICE_S = CREDIT_W'(PRICE_SPRITE);
    localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
    localparam logic [TW-1:0]       T_LAST  = TW'(IDLE_TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [TW-1:0]       idle_cnt, idle_nxt;
    logic                rr_ptr, rr_nxt;
    logic                disp_req_q, req_nxt;
    logic                disp_sel_q, sel_nxt;
    logic                refund_phase, phase_nxt;
    logic                refund_nxt, coin_ret_nxt, deny_nxt;
    logic                coin_acc;
    logic                any_req;
    logic                aff_c, aff_s;
    logic [CREDIT_W:0]   dec;
    logic [CREDIT_W:0]   sum;

    assign aff_c = (credit_q >= PRICE_C);
    assign aff_s = (credit_q >= PRICE_S);
    assign any_req = req_coffee | req_sprite;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit_q     <= '0;
            idle_cnt     <= '0;
            rr_ptr       <= 1'b0;
            disp_req_q   <= 1'b0;
            disp_sel_q   <= 1'b0;
            refund_phase <= 1'b0;
            refund_pulse <= 1'b0;
            coin_return  <= 1'b0;
            deny         <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit_q     <= credit_nxt;
            idle_cnt     <= idle_nxt;
            rr_ptr       <= rr_nxt;
            disp_req_q   <= req_nxt;
            disp_sel_q   <= sel_nxt;
            refund_phase <= phase_nxt;
            refund_pulse <= refund_nxt;
            coin_return  <= coin_ret_nxt;
            deny         <= deny_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        req_nxt      = disp_req_q;
        sel_nxt      = disp_sel_q;
        phase_nxt    = 1'b0;
        refund_nxt   = 1'b0;
        deny_nxt     = 1'b0;
        idle_nxt     = '0;
        coin_acc     = 1'b0;
        coin_ret_nxt = 1'b0;
        dec          = '0;
        sum          = '0;
        credit_nxt   = credit_q;

        // Saturation is judged on the pre-cycle credit; refunds never take coins.
        if (coin) begin
            if (state != REFUND && credit_q < MAX_C) coin_acc = 1'b1;
            else                                     coin_ret_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (req_coffee && aff_c && req_sprite && aff_s) begin
                    state_nxt = GRANT;
                    req_nxt   = 1'b1;
                    sel_nxt   = rr_ptr;
                    rr_nxt    = ~rr_ptr;
                    deny_nxt  = 1'b1;
                end else if (req_coffee && aff_c) begin
                    state_nxt = GRANT;
                    req_nxt   = 1'b1;
                    sel_nxt   = 1'b0;
                    deny_nxt  = req_sprite;
                end else if (req_sprite && aff_s) begin
                    state_nxt = GRANT;
                    req_nxt   = 1'b1;
                    sel_nxt   = 1'b1;
                    deny_nxt  = req_coffee;
                end else if (any_req) begin
                    deny_nxt = 1'b1;
                end else if (!coin && credit_q != '0) begin
                    if (idle_cnt == T_LAST) state_nxt = REFUND;
                    else                    idle_nxt  = idle_cnt + TW'(1);
                end
            end
            GRANT: begin
                deny_nxt = any_req;
                if (disp_req_q && disp.disp_ready) begin
                    dec       = {1'b0, (disp_sel_q ? PRICE_S : PRICE_C)};
                    req_nxt   = 1'b0;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                deny_nxt = any_req;
                if (disp.disp_done) state_nxt = IDLE;
            end
            REFUND: begin
                deny_nxt = any_req;
                // Phase 0 issues a pulse (or exits once drained); phase 1 is the gap.
                if (!refund_phase) begin
                    if (credit_q == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        refund_nxt = 1'b1;
                        dec        = {{CREDIT_W{1'b0}}, 1'b1};
                        phase_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        sum        = {1'b0, credit_q} + {{CREDIT_W{1'b0}}, coin_acc} - dec;
        credit_nxt = sum[CREDIT_W-1:0];
    end

    assign disp.disp_req = disp_req_q;
    assign disp.disp_sel = disp_sel_q;
    assign credit        = credit_q;
    assign led_coffee    = (state == IDLE) && aff_c;
    assign led_sprite    = (state == IDLE) && aff_s;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter with a 10-cycle idle timeout;
// expected values are worked out by hand from the controller behaviour.
module tb_vend_dispense_arbiter;

    logic       clock;
    logic       reset_n;
    logic       coin;
    logic       req_coffee;
    logic       req_sprite;
    logic [1:0] credit;
    logic       refund_pulse;
    logic       coin_return;
    logic       deny;
    logic       led_coffee;
    logic       led_sprite;
    logic       busy;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    vend_dispense_arbiter_if disp_if ();

    vend_dispense_arbiter #(
        .PRICE_COFFEE(1),
        .PRICE_SPRITE(3),
        .MAX_CREDIT  (3),
        .CREDIT_W    (2),
        .IDLE_TIMEOUT(10)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .coin        (coin),
        .req_coffee  (req_coffee),
        .req_sprite  (req_sprite),
        .disp        (disp_if.master),
        .credit      (credit),
        .refund_pulse(refund_pulse),
        .coin_return (coin_return),
        .deny        (deny),
        .led_coffee  (led_coffee),
        .led_sprite  (led_sprite),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_coin();
        coin = 1'b1;
        tick();
        coin = 1'b0;
    endtask

    task automatic pulse_req(input logic c, input logic s);
        req_coffee = c;
        req_sprite = s;
        tick();
        req_coffee = 1'b0;
        req_sprite = 1'b0;
    endtask

    task automatic pulse_ready(input logic with_coin);
        disp_if.disp_ready = 1'b1;
        coin               = with_coin;
        tick();
        disp_if.disp_ready = 1'b0;
        coin               = 1'b0;
    endtask

    task automatic pulse_done();
        disp_if.disp_done = 1'b1;
        tick();
        disp_if.disp_done = 1'b0;
    endtask

    initial begin
        reset_n            = 1'b0;
        coin               = 1'b0;
        req_coffee         = 1'b0;
        req_sprite         = 1'b0;
        disp_if.disp_ready = 1'b0;
        disp_if.disp_done  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_credit", credit, 0);
        check("rst_req", disp_if.disp_req, 0);
        check("rst_busy", busy, 0);
        check("rst_leds", {led_coffee, led_sprite}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("idle_state", dbg_state, 0);

        // coin then coffee
        pulse_coin();
        check("c1_credit", credit, 1);
        check("c1_led_coffee", led_coffee, 1);
        check("c1_led_sprite", led_sprite, 0);
        pulse_req(1'b1, 1'b0);
        check("c1_state_grant", dbg_state, 1);
        check("c1_req", disp_if.disp_req, 1);
        check("c1_sel", disp_if.disp_sel, 0);
        check("c1_deny", deny, 0);
        check("c1_led_off_busy", led_coffee, 0);
        tick();
        tick();
        check("c1_req_held", disp_if.disp_req, 1);
        pulse_ready(1'b0);
        check("c1_credit_after", credit, 0);
        check("c1_req_drop", disp_if.disp_req, 0);
        check("c1_wait_done", dbg_state, 2);
        pulse_done();
        check("c1_back_idle", dbg_state, 0);
        check("c1_busy", busy, 0);

        // saturation then sprite
        repeat (3) pulse_coin();
        check("sat_credit3", credit, 3);
        check("sat_no_ret", coin_return, 0);
        pulse_coin();
        check("sat_coin_return", coin_return, 1);
        check("sat_credit_held", credit, 3);
        check("sat_led_sprite", led_sprite, 1);
        tick();
        check("sat_ret_1cyc", coin_return, 0);
        pulse_req(1'b0, 1'b1);
        check("spr_sel", disp_if.disp_sel, 1);
        check("spr_req", disp_if.disp_req, 1);
        pulse_ready(1'b0);
        check("spr_credit", credit, 0);
        pulse_done();

        // tie arbitration, round robin
        repeat (3) pulse_coin();
        pulse_req(1'b1, 1'b1);
        check("tie1_sel", disp_if.disp_sel, 0);
        check("tie1_deny", deny, 1);
        pulse_req(1'b0, 1'b1);
        check("busy_req_deny", deny, 1);
        check("busy_sel_stable", disp_if.disp_sel, 0);
        check("busy_state", dbg_state, 1);
        pulse_ready(1'b0);
        check("tie1_credit", credit, 2);
        pulse_done();
        pulse_coin();
        check("tie2_credit", credit, 3);
        pulse_req(1'b1, 1'b1);
        check("tie2_sel", disp_if.disp_sel, 1);
        check("tie2_deny", deny, 1);
        pulse_ready(1'b0);
        check("tie2_credit_after", credit, 0);
        pulse_done();

        // unaffordable requests and coin during deduction
        pulse_req(1'b0, 1'b1);
        check("poor_deny", deny, 1);
        check("poor_idle", dbg_state, 0);
        pulse_coin();
        pulse_req(1'b0, 1'b1);
        check("poor_spr_deny", deny, 1);
        check("poor_spr_idle", busy, 0);
        pulse_req(1'b1, 1'b1);
        check("one_aff_sel", disp_if.disp_sel, 0);
        check("one_aff_deny", deny, 1);
        check("one_aff_grant", dbg_state, 1);
        pulse_ready(1'b1);
        check("ded_coin_credit", credit, 1);
        check("ded_coin_noret", coin_return, 0);
        pulse_done();

        // idle timeout refund
        pulse_coin();
        check("to_credit", credit, 2);
        repeat (9) tick();
        check("to_not_yet", dbg_state, 0);
        tick();
        check("to_refund", dbg_state, 3);
        check("to_no_pulse_yet", refund_pulse, 0);
        tick();
        check("rf_pulse1", refund_pulse, 1);
        check("rf_credit1", credit, 1);
        pulse_coin();
        check("rf_gap", refund_pulse, 0);
        check("rf_coin_return", coin_return, 1);
        check("rf_credit_kept", credit, 1);
        tick();
        check("rf_pulse2", refund_pulse, 1);
        check("rf_credit0", credit, 0);
        tick();
        check("rf_gap2", refund_pulse, 0);
        check("rf_still_refund", dbg_state, 3);
        tick();
        check("rf_back_idle", dbg_state, 0);
        check("rf_no_more", refund_pulse, 0);

        // reset mid-grant
        repeat (3) pulse_coin();
        pulse_req(1'b1, 1'b1);
        check("mr_grant_req", disp_if.disp_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_async_req", disp_if.disp_req, 0);
        check("mr_async_credit", credit, 0);
        check("mr_async_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("mr_idle", dbg_state, 0);
        repeat (3) pulse_coin();
        pulse_req(1'b1, 1'b1);
        check("mr_tie_coffee", disp_if.disp_sel, 0);
        pulse_ready(1'b0);
        check("mr_credit", credit, 2);
        pulse_done();
        check("mr_done_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
